packet_sequencer: RTL and testbench

Per-packet sequencer for the sniffer's comparator datapath. It tracks word position within each Avalon-ST frame and gates the MAC, IP, port and string comparators to their header and payload windows. At end of packet it forms a masked verdict, emits a result record to the result-writer path through a valid/ready handshake, and then clears the comparators. It sits between the input FIFO and the comparator bank, alongside the top-level controller.

---
 rtl/packet_sequencer.sv | 141 ++++++++++++++
 tb/tb_packet_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_sequencer.sv
// Per-packet sequencer: tracks word position in an Avalon-ST frame, gates the
// comparator windows, and emits a masked verdict record at end of packet.
module packet_sequencer #(
  parameter int unsigned MAC_LAST   = 2,
  parameter int unsigned IP_FIRST   = 6,
  parameter int unsigned IP_LAST    = 8,
  parameter int unsigned PORT_FIRST = 8,
  parameter int unsigned PORT_LAST  = 9,
  parameter int unsigned PAY_FIRST  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic        sop,
  input  logic        eop,
  input  logic        error,
  output logic        in_ready,
  input  logic        mac_match,
  input  logic        ip_match,
  input  logic        port_match,
  input  logic        url_match,
  input  logic [3:0]  rule_mask,
  output logic        mac_en,
  output logic        ip_en,
  output logic        port_en,
  output logic        str_en,
  output logic        clear,
  output logic [7:0]  word_idx,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [15:0] drop_cnt
);

  localparam logic [7:0] MAC_L   = 8'(MAC_LAST);
  localparam logic [7:0] IP_F    = 8'(IP_FIRST);
  localparam logic [7:0] IP_L    = 8'(IP_LAST);
  localparam logic [7:0] PORT_F  = 8'(PORT_FIRST);
  localparam logic [7:0] PORT_L  = 8'(PORT_LAST);
  localparam logic [7:0] PAY_F   = 8'(PAY_FIRST);
  localparam logic [7:0] HDR_END = 8'(PAY_FIRST - 1);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PAY,
    VERDICT,
    WAIT_ACK,
    CLEAR
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  idx_q;     // index the next in-packet beat will carry
  logic [7:0]  cur_idx;
  logic        err_q;
  logic [15:0] pkt_id;
  logic [3:0]  hit;
  logic        in_pkt;
  logic        abort;
  logic        accept;
  logic        pkt_beat;

  // An sop arriving inside an open packet is held off (not consumed) so it
  // can be taken as a fresh start once the aborted packet has been cleared.
  always_comb begin
    in_pkt   = (state == HDR) || (state == PAY);
    abort    = in_pkt && valid && sop;
    in_ready = ((state == IDLE) || in_pkt) && !abort;
    accept   = valid && in_ready;
    pkt_beat = accept && (in_pkt || sop);
    cur_idx  = in_pkt ? idx_q : '0;
    word_idx = cur_idx;
    hit      = {url_match, port_match, ip_match, mac_match} & rule_mask;
    mac_en   = pkt_beat && (cur_idx <= MAC_L);
    ip_en    = pkt_beat && (cur_idx >= IP_F) && (cur_idx <= IP_L);
    port_en  = pkt_beat && (cur_idx >= PORT_F) && (cur_idx <= PORT_L);
    str_en   = pkt_beat && (cur_idx >= PAY_F);
    clear    = rst || (state == CLEAR);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pkt_beat) begin
          if (eop)                    state_nxt = VERDICT;
          else if (HDR_END == 8'd0)   state_nxt = PAY;
          else                        state_nxt = HDR;
        end
      end
      HDR, PAY: begin
        if (abort)                    state_nxt = CLEAR;
        else if (pkt_beat) begin
          if (eop)                    state_nxt = VERDICT;
          else if ((state == HDR) && (cur_idx == HDR_END))
                                      state_nxt = PAY;
        end
      end
      VERDICT: begin
        if (err_q || (hit == '0))     state_nxt = CLEAR;
        else                          state_nxt = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (res_ready)                state_nxt = CLEAR;
      end
      CLEAR:                          state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx_q     <= '0;
      err_q     <= 1'b0;
      pkt_id    <= '0;
      drop_cnt  <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      state <= state_nxt;
      if (pkt_beat) begin
        idx_q <= (cur_idx == 8'hFF) ? 8'hFF : cur_idx + 8'd1;
        if (eop) err_q <= error;
      end
      if (abort || ((state == VERDICT) && err_q))
        drop_cnt <= drop_cnt + 16'd1;
      if (state == VERDICT) begin
        pkt_id <= pkt_id + 16'd1;
        if (!err_q && (hit != '0)) begin
          res_data  <= {pkt_id, 12'b0, hit};
          res_valid <= 1'b1;
        end
      end
      if ((state == WAIT_ACK) && res_ready)
        res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_packet_sequencer.sv
// Directed bench for packet_sequencer: a packet-level reference model checked
// every cycle, plus hand-computed literal expectations per scenario.
module tb_packet_sequencer;

  localparam int unsigned MAC_LAST   = 2;
  localparam int unsigned IP_FIRST   = 6;
  localparam int unsigned IP_LAST    = 8;
  localparam int unsigned PORT_FIRST = 8;
  localparam int unsigned PORT_LAST  = 9;
  localparam int unsigned PAY_FIRST  = 10;

  localparam int FREE = 0, JUDGE = 1, HOLD = 2, FLUSH = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0, sop = 1'b0, eop = 1'b0, error = 1'b0;
  logic        in_ready;
  logic        mac_match = 1'b0, ip_match = 1'b0, port_match = 1'b0, url_match = 1'b0;
  logic [3:0]  rule_mask = 4'hF;
  logic        mac_en, ip_en, port_en, str_en, clear;
  logic [7:0]  word_idx;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [31:0] res_data;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  packet_sequencer #(
    .MAC_LAST(MAC_LAST), .IP_FIRST(IP_FIRST), .IP_LAST(IP_LAST),
    .PORT_FIRST(PORT_FIRST), .PORT_LAST(PORT_LAST), .PAY_FIRST(PAY_FIRST)
  ) dut (
    .clk(clk), .rst(rst), .valid(valid), .sop(sop), .eop(eop), .error(error),
    .in_ready(in_ready), .mac_match(mac_match), .ip_match(ip_match),
    .port_match(port_match), .url_match(url_match), .rule_mask(rule_mask),
    .mac_en(mac_en), .ip_en(ip_en), .port_en(port_en), .str_en(str_en),
    .clear(clear), .word_idx(word_idx), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .drop_cnt(drop_cnt)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: packet-level view of the sequencer
  int          m_ph = FREE;
  bit          m_in_pkt = 1'b0;
  int          m_beat = 0;
  bit          m_err = 1'b0;
  logic [15:0] m_id = '0;
  logic [15:0] m_drop = '0;
  logic [31:0] m_rec = '0;
  logic [3:0]  m_hit;

  // Statistics feeding the literal checks
  int          cyc = 0, eop_cyc = 0, rv_cyc = 0, rises = 0, run = 0, clr_cnt = 0;
  int          n_mac = 0, n_ip = 0, n_port = 0, n_str = 0;
  logic [31:0] last_rec = '0;
  bit          rv_prev = 1'b0;

  bit busy, e_ready, acc, pk;
  int cur;

  initial begin
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (rst) begin
        chk("clear_in_reset", 32'(clear), 32'd1);
        m_ph = FREE; m_in_pkt = 1'b0; m_beat = 0; m_err = 1'b0;
        m_id = '0; m_drop = '0; m_rec = '0;
      end else begin
        busy    = (m_ph != FREE);
        e_ready = !busy && !(m_in_pkt && valid && sop);
        acc     = valid && e_ready;
        cur     = m_in_pkt ? m_beat : 0;
        pk      = acc && (m_in_pkt || sop);

        chk("in_ready", 32'(in_ready), 32'(e_ready));
        chk("enables", 32'({mac_en, ip_en, port_en, str_en}),
            32'({pk && (cur <= MAC_LAST),
                 pk && (cur >= IP_FIRST) && (cur <= IP_LAST),
                 pk && (cur >= PORT_FIRST) && (cur <= PORT_LAST),
                 pk && (cur >= PAY_FIRST)}));
        chk("clear", 32'(clear), 32'(m_ph == FLUSH));
        chk("res_valid", 32'(res_valid), 32'(m_ph == HOLD));
        if (m_ph == HOLD) chk("res_data", res_data, m_rec);
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        if (pk) chk("word_idx", 32'(word_idx), 32'(cur));

        if (pk && eop) eop_cyc = cyc;
        if (res_valid && !rv_prev) begin
          rises++; last_rec = res_data; rv_cyc = cyc; run = 1;
        end else if (res_valid) run++;
        if (clear) clr_cnt++;
        if (mac_en) n_mac++;
        if (ip_en) n_ip++;
        if (port_en) n_port++;
        if (str_en) n_str++;

        case (m_ph)
          FREE: begin
            if (m_in_pkt && valid && sop) begin
              m_drop++; m_in_pkt = 1'b0; m_ph = FLUSH;
            end else if (pk) begin
              if (eop) begin
                m_in_pkt = 1'b0; m_err = error; m_ph = JUDGE;
              end else begin
                m_in_pkt = 1'b1; m_beat = (cur >= 255) ? 255 : cur + 1;
              end
            end
          end
          JUDGE: begin
            m_hit = {url_match, port_match, ip_match, mac_match} & rule_mask;
            if (m_err) begin
              m_drop++; m_ph = FLUSH;
            end else if (m_hit != 4'h0) begin
              m_rec = {m_id, 12'h000, m_hit}; m_ph = HOLD;
            end else m_ph = FLUSH;
            m_id++;
          end
          HOLD:    if (res_ready) m_ph = FLUSH;
          default: m_ph = FREE;
        endcase
      end
      rv_prev = res_valid;
    end
  end

  // Called at a negedge; returns at the negedge after the beat is accepted.
  task automatic beat(input bit s, input bit e, input bit er);
    int n = 0;
    valid = 1'b1; sop = s; eop = e; error = er;
    #1;
    while (!in_ready && n < 40) begin
      @(negedge clk); #1; n++;
    end
    if (!in_ready) begin
      checks++; fails++;
      $display("FAIL beat_accept: in_ready stayed 0 for %0d cycles, expected 1", n);
    end
    @(negedge clk);
    valid = 1'b0; sop = 1'b0; eop = 1'b0; error = 1'b0;
  endtask

  task automatic send_pkt(input int len, input bit er);
    for (int i = 0; i < len; i++) beat(i == 0, i == len - 1, er && (i == len - 1));
  endtask

  task automatic wait_res_valid();
    int n = 0;
    while (!res_valid && n < 20) begin @(negedge clk); n++; end
    chk("res_valid_arrives", 32'(res_valid), 32'd1);
  endtask

  task automatic set_match(input bit u, input bit p, input bit i, input bit m);
    url_match = u; port_match = p; ip_match = i; mac_match = m;
  endtask

  int r0, c0, s0;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #3;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", res_data, 32'h0);
    chk("rst_word_idx", 32'(word_idx), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("rst_enables", 32'({mac_en, ip_en, port_en, str_en}), 32'd0);
    @(negedge clk);

    // 12-beat packet, mac only, all rules enabled
    set_match(0, 0, 0, 1); rule_mask = 4'b1111; res_ready = 1'b1;
    send_pkt(12, 0);
    repeat (5) @(negedge clk);
    chk("t1_mac_beats", 32'(n_mac), 32'd3);
    chk("t1_ip_beats", 32'(n_ip), 32'd3);
    chk("t1_port_beats", 32'(n_port), 32'd2);
    chk("t1_str_beats", 32'(n_str), 32'd2);
    chk("t1_latency", 32'(rv_cyc - eop_cyc), 32'd2);
    chk("t1_record", last_rec, 32'h0000_0001);
    chk("t1_clear_pulses", 32'(clr_cnt), 32'd1);

    // url only, url masked out: no record
    set_match(1, 0, 0, 0); rule_mask = 4'b0111;
    r0 = rises; c0 = clr_cnt;
    send_pkt(12, 0);
    repeat (5) @(negedge clk);
    chk("t2_no_record", 32'(rises - r0), 32'd0);
    chk("t2_clear_pulse", 32'(clr_cnt - c0), 32'd1);

    // Stalled handshake with a following sop waiting
    set_match(0, 0, 0, 1); rule_mask = 4'b1111; res_ready = 1'b0;
    send_pkt(4, 0);
    wait_res_valid();
    chk("t3_record", res_data, 32'h0002_0001);
    fork
      begin
        repeat (5) @(negedge clk);
        res_ready = 1'b1;
        @(negedge clk); #3;
        chk("t3_hold_cycles", 32'(run), 32'd6);
      end
      send_pkt(2, 0);
    join
    repeat (5) @(negedge clk);
    chk("t3_next_record", last_rec, 32'h0003_0001);

    // Errored packet with a match: dropped
    set_match(0, 0, 1, 0);
    r0 = rises;
    send_pkt(5, 1);
    repeat (5) @(negedge clk);
    chk("t4_drop_cnt", 32'(drop_cnt), 32'd1);
    chk("t4_no_record", 32'(rises - r0), 32'd0);

    // sop at beat 4 of an open packet
    set_match(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) beat(i == 0, 0, 0);
    beat(1, 0, 0);
    beat(0, 0, 0);
    beat(0, 0, 0);
    beat(0, 1, 0);
    repeat (5) @(negedge clk);
    chk("t5_drop_cnt", 32'(drop_cnt), 32'd2);

    // Long packet: word_idx saturates, str_en keeps asserting
    s0 = n_str;
    send_pkt(260, 0);
    repeat (5) @(negedge clk);
    chk("t6_str_beats", 32'(n_str - s0), 32'd250);

    // pkt_id wrap from 0xFFFF
    dut.pkt_id = 16'hFFFF;
    m_id = 16'hFFFF;
    set_match(0, 0, 0, 1);
    send_pkt(3, 0);
    repeat (5) @(negedge clk);
    chk("t7_record_ffff", last_rec, 32'hFFFF_0001);
    send_pkt(3, 0);
    repeat (5) @(negedge clk);
    chk("t7_record_wrap", last_rec, 32'h0000_0001);

    // Reset while waiting for the handshake
    res_ready = 1'b0;
    send_pkt(3, 0);
    wait_res_valid();
    chk("t8_record_pending", res_data, 32'h0001_0001);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #3;
    chk("t8_res_valid", 32'(res_valid), 32'd0);
    chk("t8_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("t8_word_idx", 32'(word_idx), 32'd0);
    res_ready = 1'b1;
    @(negedge clk);
    send_pkt(3, 0);
    repeat (5) @(negedge clk);
    chk("t8_pkt_id_reset", last_rec, 32'h0000_0001);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
